// File: rtl/riscv_shift_pkg.sv
// Shared shifter definitions: op encodings, FSM states and the log2 width helper.
package riscv_shift_pkg;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // Bits needed to index v positions (v is a power of two).
  function automatic int unsigned log2w(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: data shifted by k positions, right shifts filled with fill.
module shift_step
  import riscv_shift_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]        data,
  input  logic [1:0]             op,
  input  logic [log2w(XLEN):0]   k,
  input  logic                   fill,
  output logic [XLEN-1:0]        result
);

  logic [XLEN-1:0] fill_mask;

  always_comb begin
    fill_mask = '0;
    if (fill) fill_mask = ~({XLEN{1'b1}} >> k);
    if (op == OpSll) begin
      result = data << k;
    end else begin
      // Reserved op 2'b10 falls through to a logical right shift.
      result = (data >> k) | fill_mask;
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit shifting at most STEP positions per cycle.
// Define ITERATIVE_SHIFTER_WORD_OP_EN (XLEN=64 only) to add in_word for RV64 *W shifts.
module iterative_shifter
  import riscv_shift_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [XLEN-1:0]          in_a,
  input  logic [log2w(XLEN)-1:0]   in_shamt,
`ifdef ITERATIVE_SHIFTER_WORD_OP_EN
  input  logic                     in_word,
`endif
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result
);

  localparam int unsigned SW = log2w(XLEN);
  localparam int unsigned KW = SW + 1;
  localparam logic [KW-1:0] StepK = KW'(STEP);

  state_e          state_q;
  logic [XLEN-1:0] data_q;
  logic [SW-1:0]   rem_q;
  logic [1:0]      op_q;
  logic            word_q;

  logic            word_sel;
  logic [XLEN-1:0] a_eff;
  logic [SW-1:0]   sh_eff;
  logic [KW-1:0]   k;
  logic            fill;
  logic            last;
  logic [XLEN-1:0] stepped;

`ifdef ITERATIVE_SHIFTER_WORD_OP_EN
  assign word_sel = in_word;
`else
  assign word_sel = 1'b0;
`endif

  // Word results are sign-extended from bit 31 once the final value is known.
  function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] d, input logic w);
    return w ? XLEN'($signed(d[31:0])) : d;
  endfunction

  always_comb begin
    a_eff  = in_a;
    sh_eff = in_shamt;
    if (word_sel) begin
      // SRAW works on the sign-extended word, SLLW/SRLW on the zero-extended one.
      a_eff  = (in_op == OpSra) ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0]);
      sh_eff = SW'(in_shamt[4:0]);
    end
    k    = ({1'b0, rem_q} > StepK) ? StepK : {1'b0, rem_q};
    last = ({1'b0, rem_q} <= StepK);
    fill = (op_q == OpSra) & data_q[XLEN-1];
  end

  shift_step #(
    .XLEN(XLEN)
  ) u_step (
    .data   (data_q),
    .op     (op_q),
    .k      (k),
    .fill   (fill),
    .result (stepped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= OpSll;
      word_q  <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q   <= in_op;
            word_q <= word_sel;
            rem_q  <= sh_eff;
            if (sh_eff == '0) begin
              data_q  <= finalize(a_eff, word_sel);
              state_q <= StDone;
            end else begin
              data_q  <= a_eff;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          rem_q <= rem_q - k[SW-1:0];
          if (last) begin
            data_q  <= finalize(stepped, word_q);
            state_q <= StDone;
          end else begin
            data_q <= stepped;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (XLEN=64, STEP=4) against a plain-arithmetic model.
module tb_iterative_shifter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [63:0] in_a = '0;
  logic [5:0]  in_shamt = '0;
  logic        in_word = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iterative_shifter #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
`ifdef ITERATIVE_SHIFTER_WORD_OP_EN
    .in_word    (in_word),
`endif
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input int sh, input logic w);
    logic [31:0] a32;
    logic [31:0] r32;
    if (w) begin
      a32 = a[31:0];
      if (op == 2'b00)      r32 = a32 << sh[4:0];
      else if (op == 2'b11) r32 = $unsigned($signed(a32) >>> sh[4:0]);
      else                  r32 = a32 >> sh[4:0];
      return {{32{r32[31]}}, r32};
    end
    if (op == 2'b00)      return a << sh;
    else if (op == 2'b11) return $unsigned($signed(a) >>> sh);
    else                  return a >> sh;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: issue, wait for out_valid, hold for `hold` cycles, then drain.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [5:0] sh, input logic w, input int hold);
    int cyc;
    int eff;
    int lat;
    logic [63:0] exp;
    logic [63:0] held;
    eff = w ? int'(sh[4:0]) : int'(sh);
    lat = 1 + (eff + STEP - 1) / STEP;
    exp = model(op, a, eff, w);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_shamt = sh; in_word = w; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_result"}, out_result, exp);
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, {out_result, out_valid, in_ready} , {held, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [1:0] rop;
    logic seen_valid;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", out_result, 64'd0);

    // Directed cases
    do_req("sra_sign", 2'b11, 64'h8000_0000_0000_0000, 6'd4, 1'b0, 0);
    do_req("sll_63", 2'b00, 64'h1, 6'd63, 1'b0, 0);
    do_req("srl_0", 2'b01, 64'h1, 6'd0, 1'b0, 0);
    do_req("backpressure", 2'b01, 64'hDEAD_BEEF_0123_4567, 6'd13, 1'b0, 5);
    do_req("reserved_op", 2'b10, 64'hF000_0000_0000_00F0, 6'd9, 1'b0, 0);
    do_req("sra_63", 2'b11, 64'h8000_0000_0000_0001, 6'd63, 1'b0, 1);

    // Flush in the third SHIFT cycle
    in_valid = 1'b1; in_op = 2'b01; in_a = 64'hFFFF_0000_FFFF_0000; in_shamt = 6'd40;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'd0, out_valid, in_ready}, 64'b01);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_valid |= out_valid;
    end
    chk("flush_no_valid", 64'(seen_valid), 64'd0);
    do_req("after_flush", 2'b00, 64'hFF, 6'd8, 1'b0, 0);

    // Reset while in DONE
    in_valid = 1'b1; in_op = 2'b00; in_a = 64'h1234; in_shamt = 6'd0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("done_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done", {out_result, out_valid, in_ready}, {64'd0, 1'b0, 1'b1});

    // Reset mid-SHIFT, with flush also asserted
    in_valid = 1'b1; in_op = 2'b11; in_a = 64'h8000_0000_0000_0000; in_shamt = 6'd50;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    chk("rst_shift", {out_result, out_valid, in_ready}, {64'd0, 1'b0, 1'b1});
    seen_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seen_valid |= out_valid;
    end
    chk("rst_shift_no_valid", 64'(seen_valid), 64'd0);

`ifdef ITERATIVE_SHIFTER_WORD_OP_EN
    do_req("sraw", 2'b11, 64'h0000_0000_8000_0000, 6'd1, 1'b1, 0);
    do_req("sllw", 2'b00, 64'h0000_0000_4000_0000, 6'd1, 1'b1, 0);
    do_req("srlw_0", 2'b01, 64'hAAAA_AAAA_8000_0001, 6'd32, 1'b1, 0);
`endif

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
`ifdef ITERATIVE_SHIFTER_WORD_OP_EN
      do_req("rand", rop, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
`else
      do_req("rand", rop, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 1'b0,
             int'($urandom_range(0, 3)));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; SHALL be a power of two, 32 or 64.
REQ-002 Parameter STEP, default 4, maximum bit positions shifted per cycle; SHALL be a power of two, 1 to XLEN.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (treated as SRL).
REQ-008 in_a  input  XLEN  operand.
REQ-009 in_shamt  input  log2(XLEN)  shift amount, unsigned.
REQ-010 flush  input  1  abandon any request in flight.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_result  output  XLEN  shifted value.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 Accept when in_valid && in_ready: latch in_a, in_op, in_shamt into data and remaining registers; shamt==0 -> DONE, else -> SHIFT.
REQ-016 In SHIFT each cycle: shift data by k=min(STEP, remaining), remaining -= k; remaining reaching 0 -> DONE.
REQ-017 SLL fills zeros at LSB; SRL fills zeros at MSB; SRA fills with bit XLEN-1 of the original operand on every step.
REQ-018 Latency from accept edge to out_valid SHALL be 1 + ceil(shamt/STEP) cycles; shamt==0 gives 1.
REQ-019 In DONE, out_result SHALL be held stable until out_valid && out_ready; then -> IDLE; no accept in the same cycle (in_ready is 0 in DONE).
REQ-020 flush SHALL force IDLE on the next edge from any state, discarding data; flush has priority over accept and over the out handshake.
REQ-021 out_result SHALL equal the data register in every state; content is don't-care when out_valid is 0.
REQ-022 Result SHALL be bit-identical to the ISA shift of in_a by in_shamt for every op, operand and amount, including shamt = XLEN-1.

Reset
REQ-023 rst SHALL set state IDLE, data 0, remaining 0, op 00; hence in_ready=1, out_valid=0, out_result=0 on the next cycle.
REQ-024 rst asserted mid-SHIFT or in DONE SHALL drop the request without emitting out_valid; rst has priority over flush.

Configuration
REQ-025 Macro ITERATIVE_SHIFTER_WORD_OP_EN SHALL add input in_word (1 bit); when 1, shift uses only in_a[31:0] and shamt[4:0], SRA fills with bit 31, and out_result is the 32-bit result sign-extended to XLEN (RV64 SLLW/SRLW/SRAW).
REQ-026 Without the macro, in_word SHALL not exist and all shifts SHALL be full XLEN; macro only legal with XLEN=64.

Structure
REQ-027 Op encodings (SLL/SRL/SRA codes), FSM state encodings and the log2 width helper SHALL live in shared package riscv_shift_pkg.
REQ-028 One combinational sub-module shift_step (data, op, k, fill bit -> data shifted by k, k <= STEP) SHALL perform the per-cycle shift; the FSM, counter and handshake stay in iterative_shifter.

Verification (XLEN=64, STEP=4)
REQ-029 SRA in_a=0x8000_0000_0000_0000, shamt=4, out_ready=1 -> out_result=0xF800_0000_0000_0000, out_valid 2 cycles after accept.
REQ-030 SLL in_a=0x1, shamt=63 -> out_result=0x8000_0000_0000_0000, out_valid 17 cycles after accept; SRL same operand, shamt=0 -> 0x1 after 1 cycle.
REQ-031 Backpressure: result ready, out_ready=0 for 5 cycles -> out_valid, out_result stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-032 flush asserted in 3rd SHIFT cycle of SRL shamt=40 -> IDLE next cycle, no out_valid; following request in_a=0xFF, SLL shamt=8 -> 0xFF00.
REQ-033 rst in DONE with out_ready=0 -> out_valid=0, out_result=0, in_ready=1 next cycle.
REQ-034 With ITERATIVE_SHIFTER_WORD_OP_EN: SRA, in_word=1, in_a=0x0000_0000_8000_0000, shamt=1 -> 0xFFFF_FFFF_C000_0000; SLL, in_word=1, in_a=0x4000_0000, shamt=1 -> 0xFFFF_FFFF_8000_0000.
